// File: rtl/conv_window_loader_pkg.sv
// Shared defaults, state encoding and MAC address helper for the window loader.
package conv_window_loader_pkg;
    localparam int TAPS_DEF = 9;
    localparam int DW_DEF   = 16;
    localparam int AW_DEF   = 5;
    // Kernel words sit directly above the pixel window in MAC memory.
    localparam int KBASE    = TAPS_DEF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        FIRE  = 3'd3,
        CAPT  = 3'd4,
        OUT   = 3'd5
    } state_t;

    function automatic int mac_addr_of(input int cnt, input logic kflag, input int taps);
        return cnt + (kflag ? taps : 0);
    endfunction
endpackage

// File: rtl/conv_window_loader_if.sv
// Input stream, result stream and MAC write/enable port of the window loader.
interface conv_window_loader_if
    import conv_window_loader_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_is_kernel;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic          mac_we;
    logic          mac_en;
    logic [AW-1:0] mac_addr;
    logic [DW-1:0] mac_data;
    logic [DW-1:0] mac_out_pix;
    logic          kernel_loaded;
    logic          busy;

    modport master (
        input  in_valid, in_data, in_is_kernel, res_ready, mac_out_pix,
        output in_ready, res_valid, res_data, mac_we, mac_en, mac_addr, mac_data,
               kernel_loaded, busy
    );

    modport slave (
        output in_valid, in_data, in_is_kernel, res_ready, mac_out_pix,
        input  in_ready, res_valid, res_data, mac_we, mac_en, mac_addr, mac_data,
               kernel_loaded, busy
    );
endinterface

// File: rtl/muladdmem.sv
// 3x3 MAC window memory: pixels at 0..TAPS-1, kernel at TAPS..2*TAPS-1, registered dot product.
module muladdmem
    import conv_window_loader_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_out_pix
);
    logic [DW-1:0] r_mem [2*TAPS];
    logic [DW-1:0] w_sum;

    // Low DW bits of a product do not depend on signedness, so plain modular math is exact.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            w_sum = w_sum + r_mem[i] * r_mem[i+TAPS];
        end
    end

    always_ff @(posedge clk) begin
        if (i_we && (32'(i_addr) < 2*TAPS)) r_mem[i_addr] <= i_data;
        if (i_en) o_out_pix <= w_sum;
    end
endmodule

// File: rtl/conv_window_loader.sv
// Sequences kernel/pixel bursts into the MAC window memory and streams back one result per window.
module conv_window_loader
    import conv_window_loader_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_loader_if.master bus
);
    state_t        r_state, w_state_nxt;
    logic [3:0]    r_cnt;
    logic          r_kflag;
    logic          r_kernel_loaded;
    logic          r_res_valid;
    logic [DW-1:0] r_res_data;
    logic          r_mac_we;
    logic          r_mac_en;
    logic [AW-1:0] r_mac_addr;
    logic [DW-1:0] r_mac_data;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_last;
    logic          w_kflag_cur;
    logic [3:0]    w_cnt_cur;

    // A pixel burst cannot start until a kernel is resident; kernel bursts are always welcome.
    assign w_in_ready  = (r_state == LOAD) ||
                         ((r_state == IDLE) && !rst && (bus.in_is_kernel || r_kernel_loaded));
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_kflag_cur = (r_state == IDLE) ? bus.in_is_kernel : r_kflag;
    assign w_cnt_cur   = (r_state == IDLE) ? 4'd0 : r_cnt;
    assign w_last      = w_accept && (w_cnt_cur == 4'(TAPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_last ? DRAIN : LOAD;
            LOAD:    if (w_last) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = r_kflag ? IDLE : FIRE;
            FIRE:    w_state_nxt = CAPT;
            CAPT:    w_state_nxt = OUT;
            OUT:     if (bus.res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt           <= '0;
            r_kflag         <= 1'b0;
            r_kernel_loaded <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_data      <= '0;
            r_mac_we        <= 1'b0;
            r_mac_en        <= 1'b0;
            r_mac_addr      <= '0;
            r_mac_data      <= '0;
        end else begin
            r_mac_we <= w_accept;
            // DRAIN is the only way into FIRE, so this gives exactly one pulse per pixel window.
            r_mac_en <= (w_state_nxt == FIRE);
            if (w_accept) begin
                r_mac_addr <= AW'(mac_addr_of(int'(w_cnt_cur), w_kflag_cur, TAPS));
                r_mac_data <= bus.in_data;
                r_cnt      <= w_last ? 4'd0 : (w_cnt_cur + 4'd1);
            end
            if ((r_state == IDLE) && w_accept) r_kflag <= bus.in_is_kernel;
            if ((r_state == DRAIN) && r_kflag) r_kernel_loaded <= 1'b1;
            if (r_state == CAPT) begin
                r_res_valid <= 1'b1;
                r_res_data  <= bus.mac_out_pix;
            end else if ((r_state == OUT) && bus.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_data      = r_res_data;
    assign bus.mac_we        = r_mac_we;
    assign bus.mac_en        = r_mac_en;
    assign bus.mac_addr      = r_mac_addr;
    assign bus.mac_data      = r_mac_data;
    assign bus.kernel_loaded = r_kernel_loaded;
    assign bus.busy          = (r_state != IDLE);
endmodule

// File: tb/tb_conv_window_loader.sv
// Randomised bench for conv_window_loader + muladdmem against a dot-product reference model.
`timescale 1ns/1ps
module tb_conv_window_loader;
    import conv_window_loader_pkg::*;
    localparam int TAPS = TAPS_DEF;
    localparam int DW   = DW_DEF;
    localparam int AW   = AW_DEF;
    typedef logic [DW-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    conv_window_loader_if #(.DW(DW), .AW(AW)) bus ();

    conv_window_loader #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    muladdmem #(.TAPS(TAPS), .DW(DW), .AW(AW)) mac (
        .clk       (clk),
        .i_we      (bus.mac_we),
        .i_en      (bus.mac_en),
        .i_addr    (bus.mac_addr),
        .i_data    (bus.mac_data),
        .o_out_pix (bus.mac_out_pix)
    );

    always #5 clk = ~clk;

    // Passive log of the MAC port: every write as {addr,data}, and a running mac_en count.
    logic [AW+DW-1:0] wq[$];
    int en_pulses = 0;
    always @(negedge clk) begin
        if (bus.mac_we) wq.push_back({bus.mac_addr, bus.mac_data});
        if (bus.mac_en) en_pulses++;
    end

    word_t ref_k [TAPS];

    function automatic word_t ref_dot(input word_t k [TAPS], input word_t p [TAPS]);
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'($signed(k[i])) * longint'($signed(p[i]));
        return word_t'(s);
    endfunction

    function automatic logic [AW+DW-1:0] wq_at(input int idx);
        if (idx < wq.size()) return wq[idx];
        return '1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input word_t d, input logic k, output bit ok);
        int n = 0;
        bit acc = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_is_kernel = k;
        while (!acc && n < 40) begin
            @(negedge clk); acc = bus.in_ready;
            tick(); n++;
        end
        bus.in_valid = 1'b0;
        ok = acc;
    endtask

    // in_is_kernel is randomised after the first beat; only the first beat may decide the burst type.
    task automatic send_burst(input word_t d [TAPS], input logic k, input int max_gap, output bit ok);
        bit b;
        ok = 1;
        for (int i = 0; i < TAPS; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
            send_beat(d[i], (i == 0) ? k : 1'($urandom), b);
            ok = ok && b;
        end
    endtask

    task automatic wait_result(output word_t d, output int lat, output int en_at, output bit ok);
        ok = 0; lat = 0; en_at = -1; d = 'x;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.mac_en && en_at < 0) en_at = c;
            if (bus.res_valid) begin ok = 1; d = bus.res_data; break; end
            lat++;
        end
    endtask

    task automatic load_kernel(input word_t k [TAPS], input int max_gap, output bit ok);
        send_burst(k, 1'b1, max_gap, ok);
        tick(); tick();
        ref_k = k;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_is_kernel = 1'b1; bus.in_data = 16'h1234;
        bus.res_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({bus.in_ready, bus.res_valid, bus.res_data, bus.mac_we, bus.mac_en, bus.mac_addr,
             bus.mac_data, bus.kernel_loaded, bus.busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %0h required 0", {bus.in_ready, bus.res_valid,
                     bus.res_data, bus.mac_we, bus.mac_en, bus.mac_addr, bus.mac_data,
                     bus.kernel_loaded, bus.busy});
        end
        bus.in_valid = 1'b0;
        tick(); rst = 1'b0; tick();
    endtask

    task automatic test_basic_window();
        word_t k [TAPS] = '{16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        word_t p [TAPS] = '{16'd1, 16'd2, 16'hFFFD, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        word_t d; int lat, en_at, mark, e0; bit ok;
        mark = wq.size();
        send_burst(k, 1'b1, 0, ok);
        @(negedge clk);
        tests_run++;
        if ({ok, bus.kernel_loaded, bus.in_ready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL kernel_drain: got ok/kl/rdy %b required 100", {ok, bus.kernel_loaded, bus.in_ready});
        end
        tick(); @(negedge clk);
        tests_run++;
        if ({bus.kernel_loaded, bus.in_ready, bus.busy} !== 3'b110) begin
            tests_failed++;
            $display("FAIL kernel_loaded_rise: got kl/rdy/busy %b required 110", {bus.kernel_loaded, bus.in_ready, bus.busy});
        end
        ref_k = k;
        for (int i = 0; i < TAPS; i++) begin
            tests_run++;
            if (wq_at(mark + i) !== {AW'(KBASE + i), k[i]}) begin
                tests_failed++;
                $display("FAIL kernel_write[%0d]: got %0h required %0h", i, wq_at(mark + i), {AW'(KBASE + i), k[i]});
            end
        end
        tick();
        e0 = en_pulses; mark = wq.size();
        send_burst(p, 1'b0, 0, ok);
        wait_result(d, lat, en_at, ok);
        tests_run++;
        if (!ok || d !== ref_dot(ref_k, p) || d !== 16'hFFFC) begin
            tests_failed++;
            $display("FAIL basic_result: got %0h required fffc", d);
        end
        tests_run++;
        if (lat !== 3 || en_at !== 1) begin
            tests_failed++;
            $display("FAIL basic_latency: got lat %0d en_at %0d required 3 and 1", lat, en_at);
        end
        tick();
        tests_run++;
        if (en_pulses - e0 !== 1 || wq_at(mark + 8) !== {AW'(8), p[8]}) begin
            tests_failed++;
            $display("FAIL basic_mac_port: got %0d pulses last write %0h required 1 and %0h", en_pulses - e0, wq_at(mark + 8), {AW'(8), p[8]});
        end
    endtask

    task automatic test_back_to_back();
        word_t k [TAPS], p [TAPS];
        word_t d; int lat, en_at, mark; bit ok; longint t [2];
        for (int i = 0; i < TAPS; i++) k[i] = 16'd1;
        load_kernel(k, 0, ok);
        bus.res_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < TAPS; i++) p[i] = word_t'((w == 0) ? i + 1 : TAPS - i);
            mark = wq.size();
            send_burst(p, 1'b0, 0, ok);
            t[w] = longint'($time);
            wait_result(d, lat, en_at, ok);
            tests_run++;
            if (!ok || d !== 16'd45) begin
                tests_failed++;
                $display("FAIL b2b_result[%0d]: got %0d required 45", w, d);
            end
            for (int i = 0; i < TAPS; i++) begin
                tests_run++;
                if (wq_at(mark + i) !== {AW'(i), p[i]}) begin
                    tests_failed++;
                    $display("FAIL b2b_addr[%0d][%0d]: got %0h required %0h", w, i, wq_at(mark + i), {AW'(i), p[i]});
                end
            end
            tick();
        end
        tests_run++;
        if (t[1] - t[0] !== 64'd130) begin
            tests_failed++;
            $display("FAIL b2b_period: got %0d ns required 130", t[1] - t[0]);
        end
    endtask

    task automatic test_backpressure();
        word_t p [TAPS]; word_t d, exp; int lat, en_at; bit ok;
        for (int i = 0; i < TAPS; i++) p[i] = word_t'($urandom);
        exp = ref_dot(ref_k, p);
        bus.res_ready = 1'b0;
        send_burst(p, 1'b0, 1, ok);
        wait_result(d, lat, en_at, ok);
        tests_run++;
        if (!ok || d !== exp) begin
            tests_failed++;
            $display("FAIL bp_result: got %0h required %0h", d, exp);
        end
        bus.in_valid = 1'b1; bus.in_is_kernel = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(); @(negedge clk);
            tests_run++;
            if ({bus.res_valid, bus.res_data, bus.in_ready, bus.mac_we} !== {1'b1, exp, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v/d/rdy/we %0h required %0h", c,
                         {bus.res_valid, bus.res_data, bus.in_ready, bus.mac_we}, {1'b1, exp, 1'b0, 1'b0});
            end
        end
        tick();
        bus.in_valid = 1'b0; bus.res_ready = 1'b1;
        tick(); @(negedge clk);
        tests_run++;
        if ({bus.res_valid, bus.busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL bp_release: got v/busy %b required 00", {bus.res_valid, bus.busy});
        end
        tick();
    endtask

    task automatic test_pixel_before_kernel();
        word_t k [TAPS]; int mark; bit ok;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        bus.in_valid = 1'b1; bus.in_is_kernel = 1'b0; bus.in_data = word_t'($urandom);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.in_ready, bus.mac_we, bus.kernel_loaded} !== 3'b000) begin
                tests_failed++;
                $display("FAIL pix_stall[%0d]: got rdy/we/kl %b required 000", c, {bus.in_ready, bus.mac_we, bus.kernel_loaded});
            end
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < TAPS; i++) k[i] = word_t'($urandom_range(15, 0));
        mark = wq.size();
        load_kernel(k, 2, ok);
        for (int i = 0; i < TAPS; i++) begin
            tests_run++;
            if (!ok || wq_at(mark + i) !== {AW'(KBASE + i), k[i]}) begin
                tests_failed++;
                $display("FAIL late_kernel_write[%0d]: got %0h required %0h", i, wq_at(mark + i), {AW'(KBASE + i), k[i]});
            end
        end
    endtask

    task automatic test_reset_mid_load();
        word_t k [TAPS]; bit ok;
        for (int i = 0; i < 4; i++) send_beat(word_t'($urandom), 1'b0, ok);
        bus.in_valid = 1'b1; bus.in_is_kernel = 1'b1;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.in_ready, bus.res_valid, bus.res_data, bus.mac_we, bus.mac_en, bus.mac_addr,
             bus.mac_data, bus.kernel_loaded, bus.busy} !== '0) begin
            tests_failed++;
            $display("FAIL midload_reset: got %0h required 0", {bus.in_ready, bus.res_valid,
                     bus.res_data, bus.mac_we, bus.mac_en, bus.mac_addr, bus.mac_data,
                     bus.kernel_loaded, bus.busy});
        end
        tick(); rst = 1'b0; bus.in_is_kernel = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.in_ready, bus.mac_we} !== 2'b00) begin
                tests_failed++;
                $display("FAIL midload_stall[%0d]: got rdy/we %b required 00", c, {bus.in_ready, bus.mac_we});
            end
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < TAPS; i++) k[i] = word_t'($urandom);
        load_kernel(k, 0, ok);
    endtask

    task automatic test_truncation_gaps();
        word_t k [TAPS], p [TAPS]; word_t d; int lat, en_at; bit ok, b;
        for (int i = 0; i < TAPS; i++) begin k[i] = 16'h0100; p[i] = 16'h0100; end
        load_kernel(k, 3, ok);
        for (int i = 0; i < TAPS; i++) begin
            int g = $urandom_range(4, 2);
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                if (j > 0) begin
                    tests_run++;
                    if (bus.mac_we !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL gap_we[%0d.%0d]: got %b required 0", i, j, bus.mac_we);
                    end
                end
                tick();
            end
            send_beat(p[i], 1'b0, b);
            ok = ok && b;
        end
        wait_result(d, lat, en_at, b);
        tests_run++;
        if (!ok || !b || d !== 16'h0000 || lat !== 3) begin
            tests_failed++;
            $display("FAIL trunc_result: got %0h lat %0d required 0 lat 3", d, lat);
        end
        tick();
    endtask

    task automatic test_random();
        word_t k [TAPS], p [TAPS]; word_t d, exp; int lat, en_at, e0, dly; bit ok, b;
        for (int w = 0; w < 8; w++) begin
            if ($urandom_range(2, 0) == 0) begin
                for (int i = 0; i < TAPS; i++) k[i] = word_t'($urandom);
                e0 = en_pulses;
                load_kernel(k, 2, ok);
                tests_run++;
                if (!ok || en_pulses !== e0 || bus.kernel_loaded !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rnd_kernel[%0d]: got ok %0d pulses %0d kl %b required 1 0 1", w, ok, en_pulses - e0, bus.kernel_loaded);
                end
            end
            for (int i = 0; i < TAPS; i++) p[i] = word_t'($urandom);
            exp = ref_dot(ref_k, p);
            dly = $urandom_range(3, 0);
            bus.res_ready = (dly == 0);
            e0 = en_pulses;
            send_burst(p, 1'b0, 2, ok);
            wait_result(d, lat, en_at, b);
            repeat (dly) tick();
            bus.res_ready = 1'b1;
            tick();
            tests_run++;
            if (!ok || !b || d !== exp || lat !== 3 || en_pulses - e0 !== 1) begin
                tests_failed++;
                $display("FAIL rnd_window[%0d]: got %0h lat %0d pulses %0d required %0h lat 3 pulses 1", w, d, lat, en_pulses - e0, exp);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_is_kernel = 1'b0; bus.res_ready = 1'b1;
        test_reset();
        test_basic_window();
        test_back_to_back();
        test_backpressure();
        test_pixel_before_kernel();
        test_reset_mid_load();
        test_truncation_gaps();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
